seg7_scan: RTL

- Time-multiplexed digit scanner that sits directly upstream of the Seg7Sync/Seg7Async hex-to-7-segment decoders.
- Holds a DIGITS-nibble display value and presents one nibble at a time on ov_nibble, which feeds the decoder input.
- Drives the matching common-anode enable, a blank flag and a frame pulse.
- Double-buffers the display value so a digit set never tears mid-frame.

---
 rtl/seg7_scan_pkg.sv | 20 ++
 rtl/seg7_scan_tick_div.sv | 31 +++
 rtl/seg7_scan.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: definitions shared by the digit scanner and its prescaler.
//   ANODE_ON / ANODE_OFF : common-anode enable levels (active-low drive)
//   DEF_PRESCALE/DEF_DEAD: default slot length and dead time in clocks
//   ceil_log2            : counter width helper, never returns less than 1
package seg7_scan_pkg;

  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;

  localparam int DEF_PRESCALE = 1000;
  localparam int DEF_DEAD     = 2;

  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg7_scan_tick_div.sv
// tick_div: free-running modulo-N counter with terminal-count strobe.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (count returns to 0)
//   cnt   : current count, 0..N-1
//   tc    : high while cnt = N-1 (the cycle before the wrap)
module tick_div
  import seg7_scan_pkg::*;
#(
  parameter int N = DEF_PRESCALE,
  localparam int W = ceil_log2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Explicit terminal compare; the counter never relies on natural rollover.
  assign tc = (cnt == W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed digit scanner feeding a hex-to-7-segment decoder.
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   iv_value       : DIGITS nibbles, digit 0 in bits [3:0] (rightmost)
//   i_load         : capture strobe for iv_value
//   i_lz_en        : leading-zero suppression enable
//   ov_nibble      : nibble of the digit being scanned, to the decoder
//   ov_anode       : active-low digit enables, at most one low
//   o_blank        : segments must be forced off
//   o_frame        : one-cycle pulse at each frame wrap
// Anode/blank/frame are delayed DECODE_LATENCY extra clocks so they line up
// with the segments of a registered decoder.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = DEF_PRESCALE,
  parameter int DEAD           = DEF_DEAD,
  parameter int DECODE_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   iv_value,
  input  logic                  i_load,
  input  logic                  i_lz_en,
  output logic [3:0]            ov_nibble,
  output logic [DIGITS-1:0]     ov_anode,
  output logic                  o_blank,
  output logic                  o_frame
);

  localparam int CW = ceil_log2(PRESCALE);
  localparam int IW = ceil_log2(DIGITS);

  logic [CW-1:0]         cnt;
  logic                  slot_end;
  logic [IW-1:0]         idx;
  logic                  boundary;
  logic [4*DIGITS-1:0]   pending;
  logic [4*DIGITS-1:0]   active;
  logic [DIGITS-1:0]     supp;
  logic                  all_zero;
  logic                  dead;
  logic [DIGITS-1:0]     anode_c;

  logic [DIGITS-1:0]     anode_s;
  logic                  blank_s;
  logic                  frame_s;

  tick_div #(.N(PRESCALE)) u_prescale (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .cnt   (cnt),
    .tc    (slot_end)
  );

  assign boundary = slot_end && (idx == IW'(DIGITS - 1));

  // Digit index and double buffer. A load on the boundary bypasses pending
  // so the newest value is never held back a whole frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx     <= '0;
      pending <= '0;
      active  <= '0;
    end else begin
      if (slot_end) begin
        if (idx == IW'(DIGITS - 1)) idx <= '0;
        else                        idx <= idx + 1'b1;
      end
      if (i_load) pending <= iv_value;
      if (boundary) active <= i_load ? iv_value : pending;
    end
  end

  // supp[k]: digits k..DIGITS-1 all zero; digit 0 always shows.
  always_comb begin
    supp     = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero && (active[4*k +: 4] == 4'h0);
      supp[k]  = i_lz_en && all_zero;
    end
  end

  // Signed compare keeps DEAD = 0 well-defined (never in the dead zone).
  assign dead = (int'(cnt) < DEAD);

  always_comb begin
    anode_c = {DIGITS{ANODE_OFF}};
    if (!dead) anode_c[idx] = ANODE_ON;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_nibble <= 4'h0;
      anode_s   <= {DIGITS{ANODE_OFF}};
      blank_s   <= 1'b1;
      frame_s   <= 1'b0;
    end else begin
      ov_nibble <= active[4*int'(idx) +: 4];
      anode_s   <= anode_c;
      blank_s   <= dead || supp[idx];
      frame_s   <= boundary;
    end
  end

  if (DECODE_LATENCY == 0) begin : g_no_delay
    assign ov_anode = anode_s;
    assign o_blank  = blank_s;
    assign o_frame  = frame_s;
  end else begin : g_delay
    logic [DIGITS-1:0] anode_d [DECODE_LATENCY];
    logic              blank_d [DECODE_LATENCY];
    logic              frame_d [DECODE_LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < DECODE_LATENCY; i++) begin
          anode_d[i] <= {DIGITS{ANODE_OFF}};
          blank_d[i] <= 1'b1;
          frame_d[i] <= 1'b0;
        end
      end else begin
        anode_d[0] <= anode_s;
        blank_d[0] <= blank_s;
        frame_d[0] <= frame_s;
        for (int i = 1; i < DECODE_LATENCY; i++) begin
          anode_d[i] <= anode_d[i-1];
          blank_d[i] <= blank_d[i-1];
          frame_d[i] <= frame_d[i-1];
        end
      end
    end

    assign ov_anode = anode_d[DECODE_LATENCY-1];
    assign o_blank  = blank_d[DECODE_LATENCY-1];
    assign o_frame  = frame_d[DECODE_LATENCY-1];
  end

endmodule
